// File: rtl/casez_enc02.sv
// Priority encoder: 8-bit request word -> 3-bit index of highest set bit,
// queued in a 2-entry FIFO and streamed out with a programmable idle gap.
module casez_enc02 #(
   parameter int GAP = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] reqIn,
   input  logic       reqValid,
   output logic       reqReady,
   output logic [2:0] code,
   output logic       codeValid,
   input  logic       codeReady,
   output logic [7:0] errCount
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t     state, state_nxt;
   logic [2:0] mem [2];
   logic       rd_ptr, wr_ptr;
   logic [1:0] count, count_nxt;
   logic [3:0] gap_cnt, gap_cnt_nxt;
   logic       accept, push, pop;

   function automatic logic [2:0] prio_enc(input logic [7:0] r);
      logic [2:0] c;
      c = 3'b000;
      casez (r)
         8'b1???????: c = 3'b111;
         8'b01??????: c = 3'b110;
         8'b001?????: c = 3'b101;
         8'b0001????: c = 3'b100;
         8'b00001???: c = 3'b011;
         8'b000001??: c = 3'b010;
         8'b0000001?: c = 3'b001;
         default:     c = 3'b000;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Ready depends only on registered occupancy, never on codeReady.
   assign reqReady  = (count != 2'd2);
   assign accept    = reqValid && reqReady;
   assign push      = accept && (reqIn != 8'h00);
   assign pop       = (state == SEND) && codeReady;
   assign codeValid = (state == SEND);
   assign code      = codeValid ? mem[rd_ptr] : 3'b000;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      case (state)
         IDLE: begin
            if (count_nxt != 2'd0) state_nxt = SEND;
         end
         SEND: begin
            if (pop) begin
               if (GAP > 0) begin
                  state_nxt   = WAIT;
                  gap_cnt_nxt = 4'(GAP);
               end else if (count_nxt == 2'd0) begin
                  state_nxt = IDLE;
               end
            end
         end
         WAIT: begin
            gap_cnt_nxt = gap_cnt - 4'd1;
            if (gap_cnt <= 4'd1) begin
               gap_cnt_nxt = 4'd0;
               state_nxt   = (count_nxt != 2'd0) ? SEND : IDLE;
            end
         end
         default: begin
            state_nxt   = IDLE;
            gap_cnt_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         gap_cnt  <= 4'd0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         errCount <= 8'd0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_cnt_nxt;
         count   <= count_nxt;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (accept && (reqIn == 8'h00)) errCount <= sat_inc(errCount);
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= prio_enc(reqIn);
   end

endmodule

// File: tb/tb_casez_enc02.sv
// Directed bench for casez_enc02: one instance with GAP=0, one with GAP=3.
module tb_casez_enc02;

   typedef struct {
      logic [7:0] req;
      logic       vld;
      logic       cr;
      logic       rr;
      logic       cv;
      logic [2:0] code;
      logic [7:0] err;
   } vec_t;

   logic       clk;
   logic       rstn0, rstn3;
   logic [7:0] req0, req3;
   logic       vld0, vld3, cr0, cr3;
   logic       rr0, rr3, cv0, cv3;
   logic [2:0] code0, code3;
   logic [7:0] err0, err3;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t vq0[$];
   vec_t vq3[$];

   casez_enc02 #(.GAP(0)) u_dut0 (
      .clk(clk), .rstn(rstn0), .reqIn(req0), .reqValid(vld0), .reqReady(rr0),
      .code(code0), .codeValid(cv0), .codeReady(cr0), .errCount(err0)
   );

   casez_enc02 #(.GAP(3)) u_dut3 (
      .clk(clk), .rstn(rstn3), .reqIn(req3), .reqValid(vld3), .reqReady(rr3),
      .code(code3), .codeValid(cv3), .codeReady(cr3), .errCount(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] req, input logic vld, input logic cr,
                               input logic rr, input logic cv, input logic [2:0] code,
                               input logic [7:0] err);
      vec_t v;
      v.req = req; v.vld = vld; v.cr = cr;
      v.rr = rr; v.cv = cv; v.code = code; v.err = err;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge: drive this cycle's inputs, check this cycle's outputs.
   task automatic run_vec(input int dut, input vec_t v, input string tag);
      if (dut == 0) begin
         req0 = v.req; vld0 = v.vld; cr0 = v.cr;
         cmp({tag, " reqReady"},  32'(rr0),   32'(v.rr));
         cmp({tag, " codeValid"}, 32'(cv0),   32'(v.cv));
         cmp({tag, " code"},      32'(code0), 32'(v.code));
         cmp({tag, " errCount"},  32'(err0),  32'(v.err));
      end else begin
         req3 = v.req; vld3 = v.vld; cr3 = v.cr;
         cmp({tag, " reqReady"},  32'(rr3),   32'(v.rr));
         cmp({tag, " codeValid"}, 32'(cv3),   32'(v.cv));
         cmp({tag, " code"},      32'(code3), 32'(v.code));
         cmp({tag, " errCount"},  32'(err3),  32'(v.err));
      end
   endtask

   initial begin
      rstn0 = 1'b0; rstn3 = 1'b0;
      req0 = '0; vld0 = 1'b0; cr0 = 1'b0;
      req3 = '0; vld3 = 1'b0; cr3 = 1'b0;

      // GAP=0: stream, backpressure, push+pop at count=1, zero requests
      vq0.push_back(mk(8'h80, 1, 1, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'h40, 1, 1, 1, 1, 3'd7, 8'd0));
      vq0.push_back(mk(8'h03, 1, 1, 1, 1, 3'd6, 8'd0));
      vq0.push_back(mk(8'h01, 1, 1, 1, 1, 3'd1, 8'd0));
      vq0.push_back(mk(8'h00, 0, 1, 1, 1, 3'd0, 8'd0));
      vq0.push_back(mk(8'h00, 0, 1, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'hFF, 1, 0, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'h10, 1, 0, 1, 1, 3'd7, 8'd0));
      vq0.push_back(mk(8'h08, 1, 0, 0, 1, 3'd7, 8'd0));
      vq0.push_back(mk(8'h08, 1, 0, 0, 1, 3'd7, 8'd0));
      vq0.push_back(mk(8'h08, 1, 1, 0, 1, 3'd7, 8'd0));
      vq0.push_back(mk(8'h08, 1, 1, 1, 1, 3'd4, 8'd0));
      vq0.push_back(mk(8'h00, 0, 1, 1, 1, 3'd3, 8'd0));
      vq0.push_back(mk(8'h00, 0, 1, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'h01, 1, 0, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'h40, 1, 1, 1, 1, 3'd0, 8'd0));
      vq0.push_back(mk(8'h00, 0, 0, 1, 1, 3'd6, 8'd0));
      vq0.push_back(mk(8'h00, 0, 1, 1, 1, 3'd6, 8'd0));
      vq0.push_back(mk(8'h00, 0, 0, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'h00, 1, 1, 1, 0, 3'd0, 8'd0));
      vq0.push_back(mk(8'h00, 1, 1, 1, 0, 3'd0, 8'd1));
      vq0.push_back(mk(8'h00, 1, 1, 1, 0, 3'd0, 8'd2));
      vq0.push_back(mk(8'h00, 0, 1, 1, 0, 3'd0, 8'd3));

      // GAP=3: one zero request, two queued codes, gap, then two more queued
      vq3.push_back(mk(8'h00, 1, 0, 1, 0, 3'd0, 8'd0));
      vq3.push_back(mk(8'h02, 1, 0, 1, 0, 3'd0, 8'd1));
      vq3.push_back(mk(8'h20, 1, 0, 1, 1, 3'd1, 8'd1));
      vq3.push_back(mk(8'h00, 0, 1, 0, 1, 3'd1, 8'd1));
      vq3.push_back(mk(8'h00, 0, 1, 1, 0, 3'd0, 8'd1));
      vq3.push_back(mk(8'h00, 0, 1, 1, 0, 3'd0, 8'd1));
      vq3.push_back(mk(8'h00, 0, 1, 1, 0, 3'd0, 8'd1));
      vq3.push_back(mk(8'h00, 0, 1, 1, 1, 3'd5, 8'd1));
      vq3.push_back(mk(8'h08, 1, 1, 1, 0, 3'd0, 8'd1));
      vq3.push_back(mk(8'h08, 1, 1, 1, 0, 3'd0, 8'd1));
      vq3.push_back(mk(8'h00, 0, 1, 0, 0, 3'd0, 8'd1));

      repeat (2) @(negedge clk);
      run_vec(0, mk(8'h00, 0, 0, 1, 0, 3'd0, 8'd0), "rst0");
      run_vec(1, mk(8'h00, 0, 0, 1, 0, 3'd0, 8'd0), "rst3");
      rstn0 = 1'b1; rstn3 = 1'b1;

      foreach (vq0[i]) begin
         @(negedge clk);
         run_vec(0, vq0[i], $sformatf("g0 v%0d", i));
      end

      for (int i = 0; i < 252; i++) begin
         @(negedge clk);
         req0 = 8'h00; vld0 = 1'b1; cr0 = 1'b1;
         cmp($sformatf("zero%0d codeValid", i), 32'(cv0), 32'd0);
      end
      @(negedge clk);
      vld0 = 1'b0;
      cmp("errCount at 255", 32'(err0), 32'd255);
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         vld0 = 1'b1;
      end
      @(negedge clk);
      vld0 = 1'b0;
      cmp("errCount saturated", 32'(err0), 32'd255);
      cmp("errCount sat codeValid", 32'(cv0), 32'd0);

      foreach (vq3[i]) begin
         @(negedge clk);
         run_vec(1, vq3[i], $sformatf("g3 v%0d", i));
      end

      // Count=2 and WAIT: async reset mid-cycle, no clock edge in between
      #2 rstn3 = 1'b0;
      #1;
      cmp("async rst codeValid", 32'(cv3), 32'd0);
      cmp("async rst code", 32'(code3), 32'd0);
      cmp("async rst errCount", 32'(err3), 32'd0);
      cmp("async rst reqReady", 32'(rr3), 32'd1);
      @(negedge clk);
      rstn3 = 1'b1;
      @(negedge clk);
      run_vec(1, mk(8'h04, 1, 0, 1, 0, 3'd0, 8'd0), "post-rst accept");
      @(negedge clk);
      run_vec(1, mk(8'h00, 0, 0, 1, 1, 3'd2, 8'd0), "post-rst code");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
